// File: rtl/axi4_wr_arbiter_if.sv
// Signal bundle between upstream masters, the write arbiter and the downstream slave.
// Upstream s_* vectors are flattened: master i occupies slice i.
interface axi4_wr_arbiter_if #(
  parameter int unsigned NUM_MASTERS = 2,
  parameter int unsigned DATA_BYTES  = 4,
  parameter int unsigned ADDR_BYTES  = 1,
  parameter int unsigned NUM_ID_BITS = 4
);
  localparam int unsigned DW = DATA_BYTES * 8;
  localparam int unsigned AW = ADDR_BYTES * 8;
  localparam int unsigned IW = NUM_ID_BITS;
  localparam int unsigned SW = DATA_BYTES;

  logic [NUM_MASTERS-1:0]      s_awvalid;
  logic [NUM_MASTERS-1:0]      s_awready;
  logic [NUM_MASTERS*AW-1:0]   s_awaddr;
  logic [NUM_MASTERS*8-1:0]    s_awlen;
  logic [NUM_MASTERS*3-1:0]    s_awsize;
  logic [NUM_MASTERS*2-1:0]    s_awburst;
  logic [NUM_MASTERS*IW-1:0]   s_awid;
  logic [NUM_MASTERS-1:0]      s_wvalid;
  logic [NUM_MASTERS-1:0]      s_wready;
  logic [NUM_MASTERS*DW-1:0]   s_wdata;
  logic [NUM_MASTERS*SW-1:0]   s_wstrb;
  logic [NUM_MASTERS-1:0]      s_wlast;
  logic [NUM_MASTERS-1:0]      s_bvalid;
  logic [NUM_MASTERS-1:0]      s_bready;
  logic [NUM_MASTERS*2-1:0]    s_bresp;
  logic [NUM_MASTERS*IW-1:0]   s_bid;

  logic          m_awvalid;
  logic          m_awready;
  logic [AW-1:0] m_awaddr;
  logic [7:0]    m_awlen;
  logic [2:0]    m_awsize;
  logic [1:0]    m_awburst;
  logic [IW-1:0] m_awid;
  logic          m_wvalid;
  logic          m_wready;
  logic [DW-1:0] m_wdata;
  logic [SW-1:0] m_wstrb;
  logic          m_wlast;
  logic          m_bvalid;
  logic          m_bready;
  logic [1:0]    m_bresp;
  logic [IW-1:0] m_bid;

  // Arbiter view: owns the downstream bus, answers the upstream handshakes.
  modport master (
    input  s_awvalid, s_awaddr, s_awlen, s_awsize, s_awburst, s_awid,
    input  s_wvalid, s_wdata, s_wstrb, s_wlast, s_bready,
    output s_awready, s_wready, s_bvalid, s_bresp, s_bid,
    output m_awvalid, m_awaddr, m_awlen, m_awsize, m_awburst, m_awid,
    output m_wvalid, m_wdata, m_wstrb, m_wlast, m_bready,
    input  m_awready, m_wready, m_bvalid, m_bresp, m_bid
  );

  // Environment view: upstream masters plus downstream slave.
  modport slave (
    output s_awvalid, s_awaddr, s_awlen, s_awsize, s_awburst, s_awid,
    output s_wvalid, s_wdata, s_wstrb, s_wlast, s_bready,
    input  s_awready, s_wready, s_bvalid, s_bresp, s_bid,
    input  m_awvalid, m_awaddr, m_awlen, m_awsize, m_awburst, m_awid,
    input  m_wvalid, m_wdata, m_wstrb, m_wlast, m_bready,
    output m_awready, m_wready, m_bvalid, m_bresp, m_bid
  );
endinterface

// File: rtl/axi4_wr_arbiter.sv
// AXI4 write-channel arbiter: one whole AW/W/B transaction per grant, round-robin by default.
// Define AXI4_WR_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins).
module axi4_wr_arbiter #(
  parameter int unsigned NUM_MASTERS = 2,
  parameter int unsigned DATA_BYTES  = 4,
  parameter int unsigned ADDR_BYTES  = 1,
  parameter int unsigned NUM_ID_BITS = 4
) (
  input  logic                           aclk,
  input  logic                           aresetn,
  axi4_wr_arbiter_if.master              bus,
  output logic [$clog2(NUM_MASTERS)-1:0] grant,
  output logic                           busy
);
  localparam int unsigned GW = $clog2(NUM_MASTERS);
  localparam int unsigned DW = DATA_BYTES * 8;
  localparam int unsigned AW = ADDR_BYTES * 8;
  localparam int unsigned IW = NUM_ID_BITS;
  localparam int unsigned SW = DATA_BYTES;

  typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_e;

  state_e        state_q, state_d;
  logic [GW-1:0] grant_q, grant_d;
  logic [GW-1:0] rr_ptr_q, rr_ptr_d;
  logic [GW-1:0] win;
  logic [GW-1:0] next_ptr;
  logic          found;
  int unsigned   idx;

  logic [AW-1:0] awaddr_a  [NUM_MASTERS];
  logic [7:0]    awlen_a   [NUM_MASTERS];
  logic [2:0]    awsize_a  [NUM_MASTERS];
  logic [1:0]    awburst_a [NUM_MASTERS];
  logic [IW-1:0] awid_a    [NUM_MASTERS];
  logic [DW-1:0] wdata_a   [NUM_MASTERS];
  logic [SW-1:0] wstrb_a   [NUM_MASTERS];

  // Per-slice unpacking of requests and gating of the upstream replies to the owner only.
  for (genvar i = 0; i < NUM_MASTERS; i++) begin : g_slice
    localparam logic [GW-1:0] IDX = GW'(i);
    logic sel;
    assign sel          = (grant_q == IDX);
    assign awaddr_a[i]  = bus.s_awaddr[i*AW +: AW];
    assign awlen_a[i]   = bus.s_awlen[i*8 +: 8];
    assign awsize_a[i]  = bus.s_awsize[i*3 +: 3];
    assign awburst_a[i] = bus.s_awburst[i*2 +: 2];
    assign awid_a[i]    = bus.s_awid[i*IW +: IW];
    assign wdata_a[i]   = bus.s_wdata[i*DW +: DW];
    assign wstrb_a[i]   = bus.s_wstrb[i*SW +: SW];

    assign bus.s_awready[i]          = sel && (state_q == ADDR) && bus.m_awready;
    assign bus.s_wready[i]           = sel && (state_q == DATA) && bus.m_wready;
    assign bus.s_bvalid[i]           = sel && (state_q == RESP) && bus.m_bvalid;
    assign bus.s_bresp[i*2 +: 2]     = sel ? bus.m_bresp : 2'b00;
    assign bus.s_bid[i*IW +: IW]     = sel ? bus.m_bid : '0;
  end

  // Search for the first requester starting at rr_ptr, wrapping at NUM_MASTERS.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
      idx = 32'(rr_ptr_q) + i;
      if (idx >= NUM_MASTERS) idx = idx - NUM_MASTERS;
      if (!found && bus.s_awvalid[GW'(idx)]) begin
        found = 1'b1;
        win   = GW'(idx);
      end
    end
  end

`ifdef AXI4_WR_ARB_FIXED_PRIO_EN
  assign next_ptr = '0;
`else
  assign next_ptr = (grant_q == GW'(NUM_MASTERS - 1)) ? '0 : grant_q + GW'(1);
`endif

  // Next state and downstream passthroughs of the registered owner.
  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    rr_ptr_d      = rr_ptr_q;
    bus.m_awvalid = 1'b0;
    bus.m_wvalid  = 1'b0;
    bus.m_bready  = 1'b0;
    bus.m_awaddr  = awaddr_a[grant_q];
    bus.m_awlen   = awlen_a[grant_q];
    bus.m_awsize  = awsize_a[grant_q];
    bus.m_awburst = awburst_a[grant_q];
    bus.m_awid    = awid_a[grant_q];
    bus.m_wdata   = wdata_a[grant_q];
    bus.m_wstrb   = wstrb_a[grant_q];
    bus.m_wlast   = bus.s_wlast[grant_q];

    case (state_q)
      IDLE: begin
        if (found) begin
          grant_d = win;
          state_d = ADDR;
        end
      end
      ADDR: begin
        bus.m_awvalid = bus.s_awvalid[grant_q];
        if (bus.m_awvalid && bus.m_awready) state_d = DATA;
      end
      DATA: begin
        bus.m_wvalid = bus.s_wvalid[grant_q];
        if (bus.m_wvalid && bus.m_wready && bus.m_wlast) state_d = RESP;
      end
      RESP: begin
        bus.m_bready = bus.s_bready[grant_q];
        if (bus.m_bvalid && bus.m_bready) begin
          rr_ptr_d = next_ptr;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  assign grant = grant_q;
  assign busy  = (state_q != IDLE);
endmodule

// File: tb/tb_axi4_wr_arbiter.sv
// Directed bench for axi4_wr_arbiter with two masters and a scripted downstream slave.
module tb_axi4_wr_arbiter;
  localparam int unsigned NM = 2;

  logic       aclk = 1'b0;
  logic       aresetn = 1'b0;
  logic [0:0] grant;
  logic       busy;

  always #5 aclk = ~aclk;

  axi4_wr_arbiter_if #(.NUM_MASTERS(NM), .DATA_BYTES(4), .ADDR_BYTES(1), .NUM_ID_BITS(4)) bus ();

  axi4_wr_arbiter #(.NUM_MASTERS(NM), .DATA_BYTES(4), .ADDR_BYTES(1), .NUM_ID_BITS(4)) dut (
    .aclk    (aclk),
    .aresetn (aresetn),
    .bus     (bus),
    .grant   (grant),
    .busy    (busy)
  );

  logic [1:0]  awvalid_t, wvalid_t, wlast_t, bready_t;
  logic [7:0]  awaddr_t  [2];
  logic [7:0]  awlen_t   [2];
  logic [2:0]  awsize_t  [2];
  logic [1:0]  awburst_t [2];
  logic [3:0]  awid_t    [2];
  logic [31:0] wdata_t   [2];
  logic [3:0]  wstrb_t   [2];
  logic        awready_t, wready_t, bvalid_t;
  logic [1:0]  bresp_t;
  logic [3:0]  bid_t;
  logic [1:0]  s_bresp_o [2];
  logic [3:0]  s_bid_o   [2];

  assign bus.s_awvalid = awvalid_t;
  assign bus.s_awaddr  = {awaddr_t[1], awaddr_t[0]};
  assign bus.s_awlen   = {awlen_t[1], awlen_t[0]};
  assign bus.s_awsize  = {awsize_t[1], awsize_t[0]};
  assign bus.s_awburst = {awburst_t[1], awburst_t[0]};
  assign bus.s_awid    = {awid_t[1], awid_t[0]};
  assign bus.s_wvalid  = wvalid_t;
  assign bus.s_wdata   = {wdata_t[1], wdata_t[0]};
  assign bus.s_wstrb   = {wstrb_t[1], wstrb_t[0]};
  assign bus.s_wlast   = wlast_t;
  assign bus.s_bready  = bready_t;
  assign bus.m_awready = awready_t;
  assign bus.m_wready  = wready_t;
  assign bus.m_bvalid  = bvalid_t;
  assign bus.m_bresp   = bresp_t;
  assign bus.m_bid     = bid_t;
  assign s_bresp_o[0]  = bus.s_bresp[1:0];
  assign s_bresp_o[1]  = bus.s_bresp[3:2];
  assign s_bid_o[0]    = bus.s_bid[3:0];
  assign s_bid_o[1]    = bus.s_bid[7:4];

`ifdef AXI4_WR_ARB_FIXED_PRIO_EN
  localparam logic SECOND = 1'b0;
`else
  localparam logic SECOND = 1'b1;
`endif

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic clear_inputs();
    awvalid_t = '0; wvalid_t = '0; wlast_t = '0; bready_t = '0;
    awready_t = 1'b0; wready_t = 1'b0; bvalid_t = 1'b0; bresp_t = '0; bid_t = '0;
    for (int i = 0; i < 2; i++) begin
      awaddr_t[i] = '0; awlen_t[i] = '0; awsize_t[i] = '0; awburst_t[i] = '0;
      awid_t[i] = '0; wdata_t[i] = '0; wstrb_t[i] = '0;
    end
  endtask

  // Drives one transaction from master mi and follows it cycle by cycle; call at a negedge.
  task automatic run_txn(input logic mi, input logic [7:0] addr, input int beats,
                         input logic [31:0] dbase, input logic [3:0] id,
                         input logic [1:0] resp, input logic [3:0] bidv,
                         input logic [7:0] wpat, input int abort_at,
                         output int aw_cyc, output int n_cyc);
    int beat, dcyc;
    bit aw_done, b_done;
    beat = 0; dcyc = 0; aw_done = 0; b_done = 0; aw_cyc = -1; n_cyc = 0;
    awaddr_t[mi] = addr; awlen_t[mi] = 8'(beats - 1); awsize_t[mi] = 3'd2;
    awburst_t[mi] = 2'd1; awid_t[mi] = id; wstrb_t[mi] = 4'hF; bready_t[mi] = 1'b1;
    for (int cyc = 0; cyc < 40 && !b_done; cyc++) begin
      awvalid_t[mi] = !aw_done;
      wvalid_t[mi]  = (beat < beats);
      wdata_t[mi]   = dbase + 32'(beat);
      wlast_t[mi]   = (beat == beats - 1);
      awready_t     = 1'b1;
      if (aw_done && beat < beats) begin
        wready_t = (dcyc < 8) ? wpat[3'(dcyc)] : 1'b1;
        dcyc++;
      end else begin
        wready_t = 1'b0;
      end
      bvalid_t = (beat == beats);
      bresp_t  = resp;
      bid_t    = bidv;
      if (abort_at > 0 && beat == abort_at) begin
        wready_t = 1'b1;
        #2 aresetn = 1'b0;
        #1;
        check("rst_m_wvalid", 32'(bus.m_wvalid), 32'd0);
        check("rst_s_wready", 32'(bus.s_wready), 32'd0);
        check("rst_m_awvalid", 32'(bus.m_awvalid), 32'd0);
        check("rst_s_awready", 32'(bus.s_awready), 32'd0);
        check("rst_m_bready", 32'(bus.m_bready), 32'd0);
        check("rst_s_bvalid", 32'(bus.s_bvalid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_grant", 32'(grant), 32'd0);
        break;
      end
      #1;
      if (!aw_done) check("w_stall", 32'({bus.m_wvalid, bus.s_wready[mi]}), 32'd0);
      if (bus.m_awvalid && !aw_done) begin
        aw_cyc = cyc;
        check("aw_grant", 32'(grant), 32'(mi));
        check("aw_addr", 32'(bus.m_awaddr), 32'(addr));
        check("aw_len", 32'(bus.m_awlen), 32'(beats - 1));
        check("aw_id", 32'(bus.m_awid), 32'(id));
        check("aw_rdy", 32'(bus.s_awready[mi]), 32'd1);
        check("aw_other_rdy", 32'(bus.s_awready[~mi]), 32'd0);
        aw_done = 1;
      end
      if (bus.m_wvalid && bus.m_wready) begin
        check("w_data", bus.m_wdata, dbase + 32'(beat));
        check("w_last", 32'(bus.m_wlast), 32'(beat == beats - 1));
        beat++;
      end
      if (bus.m_bvalid && bus.m_bready) begin
        check("b_valid", 32'(bus.s_bvalid[mi]), 32'd1);
        check("b_other_valid", 32'(bus.s_bvalid[~mi]), 32'd0);
        check("b_resp", 32'(s_bresp_o[mi]), 32'(resp));
        check("b_id", 32'(s_bid_o[mi]), 32'(bidv));
        b_done = 1;
      end
      n_cyc = cyc + 1;
      @(negedge aclk);
    end
    awvalid_t[mi] = 1'b0; wvalid_t[mi] = 1'b0; wlast_t[mi] = 1'b0; bready_t[mi] = 1'b0;
    bvalid_t = 1'b0; wready_t = 1'b0;
    if (abort_at == 0) check("txn_done", 32'(b_done), 32'd1);
  endtask

  initial begin
    int aw_cyc, n_cyc;
    clear_inputs();
    // Reset state with every request and downstream reply asserted.
    @(negedge aclk);
    awvalid_t = 2'b11; wvalid_t = 2'b11; bready_t = 2'b11;
    awready_t = 1'b1; wready_t = 1'b1; bvalid_t = 1'b1;
    awaddr_t[1] = 8'h30; awlen_t[1] = 8'd0; awsize_t[1] = 3'd2; awburst_t[1] = 2'd1; awid_t[1] = 4'h3;
    repeat (2) @(negedge aclk);
    #1;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_grant", 32'(grant), 32'd0);
    check("reset_m_valids", 32'({bus.m_awvalid, bus.m_wvalid, bus.m_bready}), 32'd0);
    check("reset_s_readies", 32'({bus.s_awready, bus.s_wready, bus.s_bvalid}), 32'd0);
    @(negedge aclk);
    wvalid_t = '0; bready_t = '0; awready_t = 1'b0; wready_t = 1'b0; bvalid_t = 1'b0;
    aresetn = 1'b1;

    // Both masters requesting from reset release.
    run_txn(1'b0, 8'h10, 1, 32'h0000_00E0, 4'h1, 2'd0, 4'h1, 8'hFF, 0, aw_cyc, n_cyc);
    check("first_aw_latency", 32'(aw_cyc), 32'd1);
    check("min_txn_cycles", 32'(n_cyc), 32'd4);
    awvalid_t = 2'b11;
    run_txn(SECOND, 8'h30, 2, 32'h0000_00D0, 4'h3, 2'd2, 4'h5, 8'hFF, 0, aw_cyc, n_cyc);
    awvalid_t = 2'b11;
    run_txn(1'b0, 8'h14, 1, 32'h0000_00E8, 4'h2, 2'd0, 4'h2, 8'hFF, 0, aw_cyc, n_cyc);
    awvalid_t = 2'b00;

    // Single master 4-beat burst.
    run_txn(1'b0, 8'h10, 4, 32'h0000_00A0, 4'h7, 2'd0, 4'h7, 8'hFF, 0, aw_cyc, n_cyc);
    check("single_aw_latency", 32'(aw_cyc), 32'd1);
    check("single_cycles", 32'(n_cyc), 32'd7);
    #1 check("single_grant_after", 32'(grant), 32'd0);
    check("single_busy_after", 32'(busy), 32'd0);

    // W presented three cycles ahead of AW.
    wvalid_t[1] = 1'b1; wdata_t[1] = 32'h0000_00B0; wlast_t[1] = 1'b1; wready_t = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1 check("early_w_stall", 32'({bus.m_wvalid, bus.s_wready[1], busy}), 32'd0);
      @(negedge aclk);
    end
    run_txn(1'b1, 8'h50, 1, 32'h0000_00B0, 4'h9, 2'd1, 4'h9, 8'hFF, 0, aw_cyc, n_cyc);

    // m_wready pattern 1,0,0,1 then steady on a 4-beat burst.
    run_txn(1'b0, 8'h20, 4, 32'h0000_00C0, 4'h4, 2'd0, 4'h4, 8'b1111_1001, 0, aw_cyc, n_cyc);
    check("bp_cycles", 32'(n_cyc), 32'd9);

    // Reset during DATA of master 1, after two of four beats.
    run_txn(1'b1, 8'h40, 4, 32'h0000_0090, 4'h6, 2'd0, 4'h6, 8'hFF, 2, aw_cyc, n_cyc);
    clear_inputs();
    repeat (2) @(negedge aclk);
    aresetn = 1'b1;
    awvalid_t = 2'b11;
    awaddr_t[1] = 8'h44; awlen_t[1] = 8'd0; awid_t[1] = 4'h6;
    run_txn(1'b0, 8'h60, 2, 32'h0000_0070, 4'hA, 2'd0, 4'hA, 8'hFF, 0, aw_cyc, n_cyc);
    check("post_reset_aw_latency", 32'(aw_cyc), 32'd1);
    awvalid_t = 2'b00;

    repeat (2) @(negedge aclk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
